// File: rtl/sdram_wr_port.sv
// Write-side user port of the SDRAM port arbiter: packs sample pairs into SDRAM words
// through a first-word-fall-through FIFO and issues auto-incrementing write bursts.
module sdram_wr_port #(
    parameter int DATA_DW          = 16,
    parameter int SDRAM_ADDRS_WIDE = 21,
    parameter int SDRAM_DATA_WIDE  = 32,
    parameter int BURST_LEN        = 128,
    parameter int FIFO_DEPTH       = 512
) (
    input  logic                        i_sdram_clk,
    input  logic                        i_rst,
    input  logic                        i_port_wr_start,
    input  logic [SDRAM_ADDRS_WIDE-1:0] i_port_wr_addrs,
    input  logic [SDRAM_ADDRS_WIDE-1:0] i_port_wr_length,
    input  logic [DATA_DW-1:0]          i_port_wr_data,
    input  logic                        i_port_wr_data_vld,
    output logic                        o_port_wr_data_ready,
    output logic                        o_port_wr_done,
    output logic                        o_port_wr_ovf,
    output logic [SDRAM_ADDRS_WIDE-1:0] o_sdram_addrs,
    output logic [7:0]                  o_sdram_wr_lengths,
    output logic                        o_wr_en,
    input  logic                        i_sdram_wr_done,
    input  logic                        i_sdram_data_req,
    output logic [SDRAM_DATA_WIDE-1:0]  o_sdram_data,
    output logic                        o_sdram_unf
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [SDRAM_ADDRS_WIDE-1:0] BURST_W   = SDRAM_ADDRS_WIDE'(BURST_LEN);
    localparam logic [CW-1:0]               READY_MAX = CW'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    state_t state, state_nxt;

    logic                        start_d;
    logic                        start_edge;
    logic [SDRAM_ADDRS_WIDE-1:0] samp_left;
    logic [SDRAM_ADDRS_WIDE-1:0] words_left;
    logic [SDRAM_ADDRS_WIDE-1:0] burst_words;
    logic [SDRAM_ADDRS_WIDE-1:0] count_ext;
    logic [SDRAM_DATA_WIDE-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               fifo_count;
    logic [DATA_DW-1:0]          pack_lo;
    logic                        pack_half;
    logic                        take;
    logic                        push;
    logic                        pop;
    logic [SDRAM_DATA_WIDE-1:0]  push_word;
    logic                        burst_go;
    logic                        burst_ack;
    logic                        frame_end;

    assign start_edge   = i_port_wr_start & ~start_d;
    assign burst_words  = (words_left >= BURST_W) ? BURST_W : words_left;
    assign count_ext    = SDRAM_ADDRS_WIDE'(fifo_count);
    assign take         = i_port_wr_data_vld & o_port_wr_data_ready & ~start_edge;
    assign pop          = i_sdram_data_req & (fifo_count != '0) & ~start_edge;
    assign o_sdram_data = (fifo_count != '0) ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge i_sdram_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // A start edge restarts the frame from any state.
    always_comb begin
        state_nxt = state;
        if (start_edge) begin
            state_nxt = (i_port_wr_length == '0) ? IDLE : FILL;
        end else begin
            case (state)
                FILL:    if (burst_go)  state_nxt = WRITE;
                WRITE:   if (burst_ack) state_nxt = frame_end ? IDLE : FILL;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        burst_go  = 1'b0;
        burst_ack = 1'b0;
        frame_end = 1'b0;
        o_port_wr_data_ready = (state != IDLE) && (samp_left != '0) && (fifo_count <= READY_MAX);
        if (!start_edge) begin
            burst_go  = (state == FILL) && (count_ext >= burst_words);
            burst_ack = (state == WRITE) && i_sdram_wr_done;
            frame_end = burst_ack && (words_left == burst_words);
        end
    end

    // An odd final sample is pushed alone with a zero upper half.
    always_comb begin
        push      = 1'b0;
        push_word = {i_port_wr_data, pack_lo};
        if (take) begin
            if (pack_half) begin
                push = 1'b1;
            end else if (samp_left == SDRAM_ADDRS_WIDE'(1)) begin
                push      = 1'b1;
                push_word = {{DATA_DW{1'b0}}, i_port_wr_data};
            end
        end
    end

    always_ff @(posedge i_sdram_clk) begin
        if (push) fifo_mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge i_sdram_clk) begin
        if (i_rst) begin
            start_d            <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_count         <= '0;
            pack_lo            <= '0;
            pack_half          <= 1'b0;
            samp_left          <= '0;
            words_left         <= '0;
            o_sdram_addrs      <= '0;
            o_sdram_wr_lengths <= '0;
            o_wr_en            <= 1'b0;
            o_port_wr_done     <= 1'b0;
            o_port_wr_ovf      <= 1'b0;
            o_sdram_unf        <= 1'b0;
        end else begin
            start_d        <= i_port_wr_start;
            o_port_wr_done <= 1'b0;
            if (start_edge) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fifo_count     <= '0;
                pack_lo        <= '0;
                pack_half      <= 1'b0;
                o_port_wr_ovf  <= 1'b0;
                o_sdram_unf    <= 1'b0;
                o_wr_en        <= 1'b0;
                o_sdram_addrs  <= i_port_wr_addrs;
                samp_left      <= i_port_wr_length;
                words_left     <= (i_port_wr_length >> 1) + SDRAM_ADDRS_WIDE'(i_port_wr_length[0]);
                o_port_wr_done <= (i_port_wr_length == '0);
            end else begin
                if (i_port_wr_data_vld && !o_port_wr_data_ready) o_port_wr_ovf <= 1'b1;
                if (i_sdram_data_req && (fifo_count == '0))      o_sdram_unf   <= 1'b1;
                if (take) begin
                    samp_left <= samp_left - SDRAM_ADDRS_WIDE'(1);
                    pack_half <= ~pack_half & ~push;
                    if (!pack_half) pack_lo <= i_port_wr_data;
                end
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + CW'(1);
                    2'b01:   fifo_count <= fifo_count - CW'(1);
                    default: fifo_count <= fifo_count;
                endcase
                if (burst_go) begin
                    o_wr_en            <= 1'b1;
                    o_sdram_wr_lengths <= 8'(burst_words - SDRAM_ADDRS_WIDE'(1));
                end
                if (burst_ack) begin
                    o_wr_en        <= 1'b0;
                    o_sdram_addrs  <= o_sdram_addrs + burst_words;
                    words_left     <= words_left - burst_words;
                    o_port_wr_done <= frame_end;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_wr_port.sv
// Self-checking bench for sdram_wr_port: a frame-level model (sample queue, burst list)
// plus a behavioural arbiter that consumes bursts.
module tb_sdram_wr_port;
    localparam int DW    = 16;
    localparam int AW    = 21;
    localparam int WW    = 32;
    localparam int BL    = 128;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addrs;
    logic [AW-1:0] length;
    logic [DW-1:0] wdata;
    logic          vld;
    logic          ready;
    logic          done;
    logic          ovf;
    logic [AW-1:0] sd_addrs;
    logic [7:0]    sd_len;
    logic          wr_en;
    logic          wr_done;
    logic          data_req;
    logic [WW-1:0] sd_data;
    logic          unf;

    sdram_wr_port #(
        .DATA_DW(DW), .SDRAM_ADDRS_WIDE(AW), .SDRAM_DATA_WIDE(WW),
        .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_sdram_clk(clk),
        .i_rst(rst),
        .i_port_wr_start(start),
        .i_port_wr_addrs(addrs),
        .i_port_wr_length(length),
        .i_port_wr_data(wdata),
        .i_port_wr_data_vld(vld),
        .o_port_wr_data_ready(ready),
        .o_port_wr_done(done),
        .o_port_wr_ovf(ovf),
        .o_sdram_addrs(sd_addrs),
        .o_sdram_wr_lengths(sd_len),
        .o_wr_en(wr_en),
        .i_sdram_wr_done(wr_done),
        .i_sdram_data_req(data_req),
        .o_sdram_data(sd_data),
        .o_sdram_unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } burst_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        int            n_bursts;
        logic [7:0]    last_len;
        logic [AW-1:0] last_addr;
    } frame_vec_t;

    int checks = 0;
    int errors = 0;

    int            m_samp_left;
    bit            m_half;
    logic [DW-1:0] m_hold;
    logic [WW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_unf;
    burst_t        m_bursts[$];
    bit            exp_done;
    bit            in_burst;
    bit            done_driven;
    bit            frame_complete;
    int            burst_rem;
    int            bursts_seen;
    logic [7:0]    last_len_seen;
    logic [AW-1:0] last_addr_seen;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit model_ready();
        return (m_samp_left > 0) && (m_q.size() <= DEPTH - 2);
    endfunction

    function automatic void reset_model();
        m_samp_left = 0;
        m_half      = 1'b0;
        m_hold      = '0;
        m_q.delete();
        m_bursts.delete();
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        exp_done    = 1'b0;
        in_burst    = 1'b0;
        done_driven = 1'b0;
        burst_rem   = 0;
    endfunction

    // Frame is split into BL-word chunks; the address wraps at the address width.
    function automatic void build_bursts(input logic [AW-1:0] addr, input logic [AW-1:0] len);
        int            words;
        int            c;
        logic [AW-1:0] a;
        burst_t        b;
        words = (int'(len) + 1) / 2;
        a = addr;
        while (words > 0) begin
            c = (words > BL) ? BL : words;
            b.addr = a;
            b.len  = 8'(c - 1);
            m_bursts.push_back(b);
            a = a + AW'(c);
            words -= c;
        end
    endfunction

    function automatic void accept_sample(input logic [DW-1:0] d);
        m_samp_left--;
        if (!m_half) begin
            if (m_samp_left == 0) m_q.push_back({{DW{1'b0}}, d});
            else begin
                m_hold = d;
                m_half = 1'b1;
            end
        end else begin
            m_q.push_back({d, m_hold});
            m_half = 1'b0;
        end
    endfunction

    // One clock: compare outputs with the model, then drive inputs for the next edge.
    task automatic applyStimulus(input int vld_pct, input int req_pct, input int stray_pm);
        burst_t b;
        bit     rdy;
        @(negedge clk);
        checkOutput("ready", 32'(ready), 32'(model_ready()));
        checkOutput("sdram_data", sd_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
        checkOutput("unf", 32'(unf), 32'(m_unf));
        checkOutput("done", 32'(done), 32'(exp_done));
        if (exp_done) frame_complete = 1'b1;
        exp_done = 1'b0;
        start    = 1'b0;
        vld      = 1'b0;
        data_req = 1'b0;
        wr_done  = 1'b0;
        if (done_driven) begin
            checkOutput("wr_en_drop", 32'(wr_en), 32'h0);
            done_driven = 1'b0;
            in_burst    = 1'b0;
        end else if (in_burst) begin
            checkOutput("wr_en_hold", 32'(wr_en), 32'h1);
        end else if (wr_en) begin
            if (m_bursts.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_burst: got wr_en=1 addr 0x%0h, expected no burst", sd_addrs);
            end else begin
                b = m_bursts.pop_front();
                checkOutput("burst_addr", 32'(sd_addrs), 32'(b.addr));
                checkOutput("burst_len", 32'(sd_len), 32'(b.len));
                checkOutput("burst_data_avail", 32'(m_q.size() >= int'(b.len) + 1), 32'h1);
                bursts_seen++;
                last_len_seen  = sd_len;
                last_addr_seen = sd_addrs;
            end
            in_burst  = 1'b1;
            burst_rem = int'(sd_len) + 1;
        end
        if (in_burst && burst_rem == 0) begin
            wr_done     = 1'b1;
            done_driven = 1'b1;
            exp_done    = (m_bursts.size() == 0);
        end else if (in_burst && m_q.size() > 0 && $urandom_range(99) < req_pct) begin
            data_req = 1'b1;
            burst_rem--;
        end
        rdy = model_ready();
        vld = ((m_samp_left > 0) && ($urandom_range(99) < vld_pct)) || ($urandom_range(999) < stray_pm);
        wdata = DW'($urandom);
        if (data_req) void'(m_q.pop_front());
        if (vld && !rdy) m_ovf = 1'b1;
        if (vld && rdy) accept_sample(wdata);
    endtask

    task automatic start_frame(input logic [AW-1:0] addr, input logic [AW-1:0] len);
        @(negedge clk);
        start    = 1'b1;
        addrs    = addr;
        length   = len;
        vld      = 1'b0;
        data_req = 1'b0;
        wr_done  = 1'b0;
        reset_model();
        m_samp_left    = int'(len);
        build_bursts(addr, len);
        exp_done       = (len == '0);
        frame_complete = 1'b0;
        bursts_seen    = 0;
    endtask

    task automatic finish_frame(input int vld_pct, input int req_pct, input int stray_pm, input int max_cycles);
        for (int c = 0; c < max_cycles && !frame_complete; c++) applyStimulus(vld_pct, req_pct, stray_pm);
        if (!frame_complete) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout: got no done pulse, expected one within %0d cycles", max_cycles);
        end
    endtask

    task automatic run_until_burst(input int max_cycles);
        for (int c = 0; c < max_cycles && !in_burst; c++) applyStimulus(100, 0, 0);
        if (!in_burst) begin
            checks++;
            errors++;
            $display("[TB] FAIL burst_timeout: got wr_en=0, expected a burst within %0d cycles", max_cycles);
        end
    endtask

    frame_vec_t vecs[7];

    initial begin
        vecs[0] = '{21'h000100, 21'd512, 2, 8'd127, 21'h000180};
        vecs[1] = '{21'h002000, 21'd261, 2, 8'd2,   21'h002080};
        vecs[2] = '{21'h1FFFC0, 21'd300, 2, 8'd21,  21'h000040};
        vecs[3] = '{21'h000055, 21'd1,   1, 8'd0,   21'h000055};
        vecs[4] = '{21'h000007, 21'd257, 2, 8'd0,   21'h000087};
        vecs[5] = '{21'h001000, 21'd256, 1, 8'd127, 21'h001000};
        vecs[6] = '{21'h000003, 21'd3,   1, 8'd1,   21'h000003};

        rst = 1'b1; start = 1'b0; addrs = '0; length = '0; wdata = '0;
        vld = 1'b0; wr_done = 1'b0; data_req = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("rst_ready", 32'(ready), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        checkOutput("rst_unf", 32'(unf), 32'h0);
        checkOutput("rst_data", sd_data, 32'h0);
        checkOutput("rst_addrs", 32'(sd_addrs), 32'h0);
        checkOutput("rst_len", 32'(sd_len), 32'h0);
        rst = 1'b0;
        applyStimulus(0, 0, 0);

        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].addr, vecs[i].len);
            finish_frame(100, 100, 0, 5000);
            checkOutput("vec_bursts", 32'(bursts_seen), 32'(vecs[i].n_bursts));
            checkOutput("vec_last_len", 32'(last_len_seen), 32'(vecs[i].last_len));
            checkOutput("vec_last_addr", 32'(last_addr_seen), 32'(vecs[i].last_addr));
        end

        for (int i = 0; i < 6; i++) begin
            start_frame(AW'($urandom), AW'($urandom_range(700, 1)));
            finish_frame($urandom_range(100, 40), $urandom_range(100, 30), 20, 20000);
        end

        // Reset while a burst is pending.
        start_frame(21'h000300, 21'd512);
        run_until_burst(1000);
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; data_req = 1'b0; wr_done = 1'b0;
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_wr_en", 32'(wr_en), 32'h0);
        checkOutput("midrst_ready", 32'(ready), 32'h0);
        checkOutput("midrst_data", sd_data, 32'h0);
        checkOutput("midrst_ovf", 32'(ovf), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        repeat (3) applyStimulus(0, 0, 0);

        // New start edge while a burst request is outstanding.
        start_frame(21'h000400, 21'd600);
        run_until_burst(1000);
        start_frame(21'h009000, 21'd40);
        @(posedge clk);
        #1;
        checkOutput("restart_wr_en", 32'(wr_en), 32'h0);
        checkOutput("restart_flush", sd_data, 32'h0);
        checkOutput("restart_addr", 32'(sd_addrs), 32'h009000);
        finish_frame(100, 100, 0, 2000);

        // No consumer: FIFO fills, ready drops, dropped samples raise ovf.
        start_frame(21'h000000, 21'd2000);
        for (int c = 0; c < 1200; c++) applyStimulus(100, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("full_ready", 32'(ready), 32'h0);
        checkOutput("full_ovf", 32'(ovf), 32'h1);

        // Zero-length frame, then an underflowing data request.
        start_frame(21'h000010, 21'd0);
        finish_frame(0, 0, 0, 4);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        data_req = 1'b1;
        m_unf    = 1'b1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        start_frame(21'h000020, 21'd4);
        finish_frame(100, 100, 0, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
